// File: rtl/fb_defines.sv
// fb_defines: shared Firebird constants (word size, opcodes, predictor FSM states)
package fb_defines;
    localparam int FB_32BITS = 32;
    localparam logic [6:0] FB_OP_JAL    = 7'b1101111;
    localparam logic [6:0] FB_OP_JALR   = 7'b1100111;
    localparam logic [6:0] FB_OP_BRANCH = 7'b1100011;
    typedef enum logic {FB_BP_INIT = 1'b0, FB_BP_RUN = 1'b1} fb_bp_state_t;
endpackage

// File: rtl/fb_sat_counter.sv
// fb_sat_counter: next value of a saturating up/down counter
module fb_sat_counter #(
    parameter int CNT_BITS = 2
) (
    input  logic [CNT_BITS-1:0] cnt,
    input  logic                inc,
    input  logic                dec,
    output logic [CNT_BITS-1:0] cnt_next
);
    always_comb cnt_next = inc ? (&cnt ? cnt : cnt + CNT_BITS'(1))
                         : dec ? (|cnt ? cnt - CNT_BITS'(1) : cnt) : cnt;
endmodule

// File: rtl/fb_branch_predictor.sv
// fb_branch_predictor: BHT next-PC predictor with training and mispredict flush; FB_PRED_PERF_EN adds perf counters
module fb_branch_predictor
    import fb_defines::*;
#(
    parameter int XLEN      = FB_32BITS,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_BITS  = 2,
    parameter int CNT_INIT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [FB_32BITS-1:0] if_inst,
    input  logic [XLEN-1:0]      if_imm,
    input  logic [XLEN-1:0]      if_rs1_data,
    output logic                 pc_src,
    output logic [XLEN-1:0]      predict_pc,
    output logic                 pred_taken,
    output logic                 pred_ready,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic                 ex_taken,
    input  logic [XLEN-1:0]      ex_target,
    input  logic                 ex_pred_taken,
    output logic                 address_src,
    output logic [XLEN-1:0]      predict_err_pc,
    output logic                 register_rst
`ifdef FB_PRED_PERF_EN
    ,
    output logic [31:0]          perf_branches,
    output logic [31:0]          perf_mispredicts
`endif
);
    localparam int IDX = $clog2(BHT_DEPTH);

    fb_bp_state_t        state;
    logic [IDX-1:0]      idx;
    logic [CNT_BITS-1:0] bht [BHT_DEPTH];
    logic [CNT_BITS-1:0] cnt_next;
    logic [IDX-1:0]      ex_idx;
    logic                is_jal, is_jalr, is_br, resolve, mis, unused;

    assign unused = &{1'b0, if_inst[31:7]};

    always_comb begin
        is_jal         = if_inst[6:0] == FB_OP_JAL;
        is_jalr        = if_inst[6:0] == FB_OP_JALR;
        is_br          = if_inst[6:0] == FB_OP_BRANCH;
        pc_src         = is_jal | is_jalr | is_br;
        pred_ready     = state == FB_BP_RUN;
        pred_taken     = (is_br && pred_ready) ? bht[if_pc[IDX-1:0]][CNT_BITS-1] : is_jal | is_jalr;
        predict_pc     = (is_jal || (is_br && pred_taken)) ? if_pc + if_imm
                       : is_jalr ? (if_rs1_data + if_imm) & ~XLEN'(1) : if_pc + XLEN'(1);
        resolve        = ex_valid & ex_is_branch;
        mis            = resolve & (ex_taken != ex_pred_taken);
        address_src    = mis;
        register_rst   = mis;
        predict_err_pc = ex_taken ? ex_target : ex_pc + XLEN'(1);
        ex_idx         = ex_pc[IDX-1:0];
    end

    fb_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
        .cnt      (bht[ex_idx]),
        .inc      (ex_taken),
        .dec      (~ex_taken),
        .cnt_next (cnt_next)
    );

    // The table is cleared by sweeping idx rather than by reset, so it maps onto RAM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FB_BP_INIT;
            idx   <= '0;
        end else if (state == FB_BP_INIT) begin
            bht[idx] <= CNT_BITS'(CNT_INIT);
            idx      <= idx + IDX'(1);
            if (idx == IDX'(BHT_DEPTH - 1)) state <= FB_BP_RUN;
        end else if (resolve) begin
            bht[ex_idx] <= cnt_next;
        end
    end

`ifdef FB_PRED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (resolve && perf_branches != '1) perf_branches <= perf_branches + 32'd1;
            if (mis && perf_mispredicts != '1) perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fb_branch_predictor.sv
// tb_fb_branch_predictor: randomized self-checking bench against a counter-table reference model
module tb_fb_branch_predictor;
    localparam int DEPTH = 64;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;

    logic        clk = 0, rst_n = 0;
    logic [31:0] if_pc = 0, if_inst = 0, if_imm = 0, if_rs1_data = 0;
    logic [31:0] ex_pc = 0, ex_target = 0;
    logic        ex_valid = 0, ex_is_branch = 0, ex_taken = 0, ex_pred_taken = 0;
    logic        pc_src, pred_taken, pred_ready, address_src, register_rst;
    logic [31:0] predict_pc, predict_err_pc;

    int n_cmp = 0, n_err = 0;
    int bht_m [DEPTH];
    bit run_m = 0;
    logic [33:0] ef;
    logic [32:0] em;

    always #5 clk = ~clk;

    fb_branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_inst(if_inst), .if_imm(if_imm),
        .if_rs1_data(if_rs1_data), .pc_src(pc_src), .predict_pc(predict_pc),
        .pred_taken(pred_taken), .pred_ready(pred_ready), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .address_src(address_src),
        .predict_err_pc(predict_err_pc), .register_rst(register_rst)
    );

    function automatic logic [33:0] exp_fetch();
        logic j, r, b, t;
        logic [31:0] n;
        j = if_inst[6:0] == JAL;
        r = if_inst[6:0] == JALR;
        b = if_inst[6:0] == BR;
        t = j || r || (b && run_m && bht_m[if_pc % DEPTH] >= 2);
        if (j || (b && t)) n = if_pc + if_imm;
        else if (r) n = (if_rs1_data + if_imm) & ~32'd1;
        else n = if_pc + 1;
        return {j || r || b, t, n};
    endfunction

    function automatic logic [32:0] exp_mis();
        return {ex_valid && ex_is_branch && ex_taken != ex_pred_taken,
                ex_taken ? ex_target : ex_pc + 32'd1};
    endfunction

    function automatic logic [6:0] rand_op();
        int s;
        s = $urandom_range(0, 3);
        return s == 0 ? JAL : s == 1 ? JALR : s == 2 ? BR : 7'($urandom);
    endfunction

    task automatic set_fetch(input logic [31:0] pc, input logic [6:0] op,
                             input logic [31:0] imm, input logic [31:0] rs1);
        logic [31:0] inst;
        inst = $urandom;
        inst[6:0] = op;
        if_inst = inst; if_pc = pc; if_imm = imm; if_rs1_data = rs1;
    endtask

    task automatic set_ex(input logic v, input logic b, input logic [31:0] pc,
                          input logic t, input logic p);
        ex_valid = v; ex_is_branch = b; ex_pc = pc; ex_taken = t;
        ex_pred_taken = p; ex_target = pc + 32'd8;
    endtask

    task automatic tick();
        int i;
        @(posedge clk);
        if (run_m && ex_valid && ex_is_branch) begin
            i = ex_pc % DEPTH;
            bht_m[i] = ex_taken ? (bht_m[i] < 3 ? bht_m[i] + 1 : 3) : (bht_m[i] > 0 ? bht_m[i] - 1 : 0);
        end
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic t);
        set_ex(1, 1, pc, t, ~t);
        tick();
        set_ex(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0; run_m = 0;
        set_fetch(32'h10, BR, 32'h8, 0);
        tick(); tick();
        n_cmp++;
        if ({pred_ready, pred_taken} !== 2'b00) begin
            n_err++; $display("FAIL reset ready/taken got %b%b exp 00", pred_ready, pred_taken);
        end
        rst_n = 1;
        foreach (bht_m[i]) bht_m[i] = 1;
        for (int k = 1; k <= 64; k++) begin
            if (k >= 10 && k <= 20) set_ex(1, 1, 0, 1, 0);
            else set_ex(0, 0, 0, 0, 0);
            if (k == 10) begin
                #1; em = exp_mis(); n_cmp++;
                if ({address_src, register_rst, predict_err_pc} !== {em[32], em}) begin
                    n_err++; $display("FAIL init_mis got %b%b %h exp %b %h", address_src, register_rst, predict_err_pc, em[32], em[31:0]);
                end
            end
            tick();
            n_cmp++;
            if (pred_ready !== (k == 64)) begin
                n_err++; $display("FAIL init_ready cycle %0d got %b exp %b", k, pred_ready, k == 64);
            end
        end
        run_m = 1;
        set_ex(0, 0, 0, 0, 0);
        for (int p = 0; p <= 32'h10; p += 32'h10) begin
            set_fetch(p, BR, 32'h8, 0);
            #1; ef = exp_fetch(); n_cmp++;
            if ({pc_src, pred_taken, predict_pc} !== ef) begin
                n_err++; $display("FAIL post_init_fetch pc=%h got %b/%b/%h exp %b/%b/%h", p, pc_src, pred_taken, predict_pc, ef[33], ef[32], ef[31:0]);
            end
        end
    endtask

    task automatic test_training();
        for (int k = 0; k < 4; k++) begin
            train(32'h10, k < 2);
            set_fetch(32'h10, BR, 32'h8, 0);
            #1; ef = exp_fetch(); n_cmp++;
            if ({pc_src, pred_taken, predict_pc} !== ef) begin
                n_err++; $display("FAIL train step %0d got %b/%b/%h exp %b/%b/%h", k, pc_src, pred_taken, predict_pc, ef[33], ef[32], ef[31:0]);
            end
        end
    endtask

    task automatic test_mispredict();
        for (int k = 0; k < 20; k++) begin
            if (k == 0) set_ex(1, 1, 32'h20, 0, 1);
            else set_ex(1'($urandom), 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom));
            #1; em = exp_mis(); n_cmp++;
            if ({address_src, register_rst} !== {2{em[32]}} || (em[32] && predict_err_pc !== em[31:0])) begin
                n_err++; $display("FAIL mispredict %0d got %b%b %h exp %b %h", k, address_src, register_rst, predict_err_pc, em[32], em[31:0]);
            end
            tick();
        end
        set_ex(0, 0, 0, 0, 0);
    endtask

    task automatic test_jumps();
        for (int k = 0; k < 24; k++) begin
            if (k == 0) set_fetch(32'h40, JALR, 32'h4, 32'h101);
            else set_fetch($urandom, k < 12 ? (k % 2 ? JAL : JALR) : 7'($urandom), $urandom, $urandom);
            #1; ef = exp_fetch(); n_cmp++;
            if ({pc_src, pred_taken, predict_pc} !== ef) begin
                n_err++; $display("FAIL jump %0d op=%b got %b/%b/%h exp %b/%b/%h", k, if_inst[6:0], pc_src, pred_taken, predict_pc, ef[33], ef[32], ef[31:0]);
            end
        end
    endtask

    task automatic test_saturation();
        int plan [7] = '{10, -1, -9, 1, 1, 0, 0};
        for (int s = 0; s < 7; s++) begin
            if (s < 5) repeat (plan[s] < 0 ? -plan[s] : plan[s]) train(32'h30, plan[s] > 0);
            else if (s == 5) begin train(32'h50, 1); train(32'h90, 1); end
            set_fetch(s == 6 ? 32'hD0 : s == 5 ? 32'h10 : 32'h30, BR, $urandom, 0);
            #1; ef = exp_fetch(); n_cmp++;
            if ({pc_src, pred_taken, predict_pc} !== ef) begin
                n_err++; $display("FAIL saturation step %0d got %b/%b/%h exp %b/%b/%h", s, pc_src, pred_taken, predict_pc, ef[33], ef[32], ef[31:0]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            set_fetch($urandom_range(0, 255), $urandom_range(0, 1) ? BR : rand_op(), $urandom, $urandom);
            set_ex(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   $urandom_range(0, 3) == 0 ? if_pc : $urandom_range(0, 255), 1'($urandom), 1'($urandom));
            #1; ef = exp_fetch(); em = exp_mis(); n_cmp++;
            if ({pc_src, pred_taken, predict_pc} !== ef || address_src !== em[32] ||
                (em[32] && predict_err_pc !== em[31:0])) begin
                n_err++; $display("FAIL random %0d pc=%h got %b/%b/%h mis %b exp %b/%b/%h mis %b", k, if_pc, pc_src, pred_taken, predict_pc, address_src, ef[33], ef[32], ef[31:0], em[32]);
            end
            tick();
        end
        set_ex(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        rst_n = 0; run_m = 0;
        set_ex(1, 1, 32'h10, 1, 0);
        tick();
        set_ex(0, 0, 0, 0, 0);
        rst_n = 1;
        n_cmp++;
        if (pred_ready !== 1'b0) begin
            n_err++; $display("FAIL rerun_ready_low got %b exp 0", pred_ready);
        end
        foreach (bht_m[i]) bht_m[i] = 1;
        repeat (64) tick();
        run_m = 1;
        n_cmp++;
        if (pred_ready !== 1'b1) begin
            n_err++; $display("FAIL rerun_ready_high got %b exp 1", pred_ready);
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_fetch(i + 64 * $urandom_range(0, 3), BR, $urandom, 0);
            set_ex(1, 1, i, 1, 0);
            for (int p = 0; p < 2; p++) begin
                #1; ef = exp_fetch(); n_cmp++;
                if ({pc_src, pred_taken, predict_pc} !== ef) begin
                    n_err++; $display("FAIL rerun entry %0d phase %0d got %b/%b/%h exp %b/%b/%h", i, p, pc_src, pred_taken, predict_pc, ef[33], ef[32], ef[31:0]);
                end
                if (p == 0) begin tick(); set_ex(0, 0, 0, 0, 0); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_training();
        test_mispredict();
        test_jumps();
        test_saturation();
        test_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fb_branch_predictor.md
Name: fb_branch_predictor

Overview:
- Dynamic branch predictor for the Firebird pipeline; replaces static backward-taken/forward-not-taken prediction.
- Sits beside the IF stage. Predicts the next PC from a table of saturating counters (BHT) indexed by the fetch PC.
- Trains the counters when a branch resolves in EX/MEM. Flags mispredictions so the IF/ID, ID/EX and EX/MEM registers are flushed.
- PC is word-addressed: the sequential PC is pc + 1.

Parameters:
- XLEN, 32, datapath and PC width.
- BHT_DEPTH, 64, number of counter entries; must be a power of two, minimum 2.
- CNT_BITS, 2, saturating counter width; minimum 1.
- CNT_INIT, 1, counter value written during initialisation (weakly not-taken).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- if_pc  in  XLEN  fetch PC.
- if_inst  in  32  fetched instruction.
- if_imm  in  XLEN  sign-extended offset.
- if_rs1_data  in  XLEN  rs1 value, used by jalr.
- pc_src  out  1  1 = take predict_pc, 0 = pc + 1.
- predict_pc  out  XLEN  predicted next PC.
- pred_taken  out  1  prediction bit; carried down the pipe to ex_pred_taken.
- pred_ready  out  1  0 while the table is initialising.
- ex_valid  in  1  resolution slot valid.
- ex_is_branch  in  1  resolving instruction is B-type.
- ex_pc  in  XLEN  PC of the resolving branch.
- ex_taken  in  1  actual branch outcome.
- ex_target  in  XLEN  actual taken target, ex_pc + imm.
- ex_pred_taken  in  1  prediction made at fetch.
- address_src  out  1  1 = redirect fetch to predict_err_pc.
- predict_err_pc  out  XLEN  correct PC after a misprediction.
- register_rst  out  1  flush of pipeline registers; equals address_src.

Behaviour:
- FSM states:
  - INIT: a counter idx (log2 BHT_DEPTH bits) writes CNT_INIT to entry idx each cycle. After the write to entry BHT_DEPTH-1 the FSM moves to RUN, so INIT lasts exactly BHT_DEPTH cycles.
  - RUN: normal operation.
- Reset: rst_n = 0 at a rising edge forces INIT with idx = 0. Reset asserted mid-RUN discards all training and reinitialises the table. Perf counters (when present) clear to 0.
- Output values under reset and INIT: pred_ready = 0; pred_taken = 0 for B-type.
- Decode from if_inst[6:0]:
  - 1101111 = jal.
  - 1100111 = jalr.
  - 1100011 = B-type.
- pc_src = jal | jalr | B-type, combinational.
- predict_pc, combinational:
  - jal: if_pc + if_imm.
  - jalr: (if_rs1_data + if_imm) & ~1.
  - B-type with pred_taken = 1: if_pc + if_imm.
  - otherwise: if_pc + 1.
  - All additions are modulo 2^XLEN.
- pred_taken:
  - B-type in RUN: MSB of BHT[if_pc[IDX-1:0]].
  - jal/jalr: 1.
  - otherwise: 0.
- Misprediction, combinational: mis = ex_valid & ex_is_branch & (ex_taken != ex_pred_taken). Reported in both INIT and RUN.
  - address_src = register_rst = mis.
  - predict_err_pc = ex_taken ? ex_target : ex_pc + 1.
  - When mis = 0, predict_err_pc still carries that expression; it is don't-care.
- Training:
  - Occurs in RUN when ex_valid & ex_is_branch. Registered; BHT[ex_pc idx] updates at the next clock edge.
  - Taken: increment, saturating at 2^CNT_BITS - 1.
  - Not taken: decrement, saturating at 0.
- Updates arriving in INIT are dropped.
- Same-cycle lookup and update of the same index: the lookup sees the old value (no bypass).
- Aliasing between PCs that share low bits is permitted.
- jalr misprediction is out of scope; the target is exact at fetch.

Optional Feature:
- Macro: FB_PRED_PERF_EN.
- Defined:
  - Adds outputs perf_branches [31:0] and perf_mispredicts [31:0].
  - perf_branches increments on every resolved branch; perf_mispredicts increments on every mis.
  - Both counters are registered, count in INIT as well as RUN, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (fb_defines) holds:
  - FB_32BITS.
  - Opcode constants for jal, jalr and B-type.
  - FSM state encodings: FB_BP_INIT = 1'b0, FB_BP_RUN = 1'b1.
- One sub-module: fb_sat_counter. Parametrised CNT_BITS, combinational next-value function (inc/dec/hold with saturation); instantiated once on the update path.

Test Plan:
- Reset, then 64 idle cycles:
  - pred_ready = 0 for cycles 0..63 and 1 at cycle 64.
  - B-type at if_pc = 0x10, imm = 0x8 immediately after gives pred_taken = 0, predict_pc = 0x11.
- Two resolved taken updates for ex_pc = 0x10, target 0x18:
  - Counter goes 01 → 10 → 11.
  - The next fetch of 0x10 gives pred_taken = 1, predict_pc = 0x18.
  - Two further not-taken updates return the prediction to not-taken.
- Mispredict with ex_pred_taken = 1, ex_taken = 0, ex_pc = 0x20: address_src = register_rst = 1 and predict_err_pc = 0x21 in the same cycle.
- jalr with rs1 = 0x101, imm = 0x4: pc_src = 1, predict_pc = 0x104.
- Saturation:
  - Ten taken updates leave the counter at 3; ten not-taken updates leave it at 0.
  - Aliasing: updates to 0x50 and 0x90 both move entry 0x10 (BHT_DEPTH = 64).
- rst_n pulsed low in RUN after training: INIT repeats, and all entries return to 01.
